kuz_encrypt_core: RTL and testbench

//  Parametrised GOST R 34.12-2015 (Kuznyechik) 128-bit block encryptor; successor to the fixed 9-stage pipeline.

---
 rtl/kuz_pkg.sv | 66 ++++++
 rtl/kuz_encrypt_core_round.sv | 21 ++
 rtl/kuz_encrypt_core.sv | 112 +++++++++++
 tb/tb_kuz_encrypt_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/kuz_pkg.sv
// Shared constants, types and GF(2^8) helpers for the Kuznyechik encryptor.
package kuz_pkg;

    localparam int KEY_NUM = 10;
    localparam int BLOCK_W = 128;
    localparam int ROUNDS  = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nonlinear byte substitution pi.
    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Linear-map coefficients; entry 0 multiplies a15, entry 15 multiplies a0.
    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'hC3) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // L = sixteen applications of R(a) = (l(a15..a0), a15..a1); a15 sits in [127:120].
    function automatic logic [BLOCK_W-1:0] l_transform(input logic [BLOCK_W-1:0] a);
        logic [BLOCK_W-1:0] v;
        logic [7:0]         acc;
        v = a;
        for (int r = 0; r < 16; r++) begin
            acc = 8'h00;
            for (int i = 0; i < 16; i++) acc = acc ^ gf_mul(v[8*(15-i) +: 8], L_COEF[i]);
            v = {acc, v[BLOCK_W-1:8]};
        end
        return v;
    endfunction

endpackage

// File: rtl/kuz_encrypt_core_round.sv
// One full Kuznyechik round: key xor, byte substitution, linear mix.
module kuz_round
    import kuz_pkg::*;
(
    input  logic [BLOCK_W-1:0] st_in,
    input  logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] st_out
);

    logic [BLOCK_W-1:0] x;
    logic [BLOCK_W-1:0] s;

    // Purely combinational X[k] -> S -> L.
    always_comb begin
        x = st_in ^ key;
        s = '0;
        for (int b = 0; b < 16; b++) s[8*b +: 8] = PI[x[8*b +: 8]];
        st_out = l_transform(s);
    end

endmodule

// File: rtl/kuz_encrypt_core.sv
// Kuznyechik block encryptor: run-time key file, UNROLL rounds per clock,
// one block in flight between a valid/ready input and a held output.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The source holds data steady while valid is high and ready
// is low; out_valid/out_data stay constant in DONE until out_ready is seen.
module kuz_encrypt_core
    import kuz_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    input  logic               key_we,
    input  logic [3:0]         key_idx,
    input  logic [BLOCK_W-1:0] key_data,
    output logic               busy
);

    if (!(UNROLL == 1 || UNROLL == 3 || UNROLL == 9)) begin : g_bad_unroll
        $error("kuz_encrypt_core: UNROLL must be 1, 3 or 9");
    end

    localparam logic [3:0] RND_STEP = 4'(UNROLL);
    localparam logic [3:0] LAST_RND = 4'(ROUNDS - UNROLL);

    state_t             state;
    state_t             state_nx;
    logic [3:0]         rnd;
    logic [BLOCK_W-1:0] st;
    logic [BLOCK_W-1:0] key_file [KEY_NUM];
    logic [BLOCK_W-1:0] chain [UNROLL+1];
    logic               in_fire;
    logic               last_step;

    assign chain[0]  = st;
    assign in_ready  = (state == ST_IDLE) && !key_we && !rst;
    assign in_fire   = in_valid && in_ready;
    assign last_step = (rnd == LAST_RND);
    assign busy      = (state != ST_IDLE);

    // Chained rounds; stage j uses key K[rnd+j].
    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        logic [3:0] kidx;
        assign kidx = rnd + 4'(j);
        kuz_round u_round (
            .st_in  (chain[j]),
            .key    (key_file[kidx]),
            .st_out (chain[j+1])
        );
    end

    // Key file: no reset, writable only while idle, out-of-range indices dropped.
    always_ff @(posedge clk) begin
        if (key_we && state == ST_IDLE && key_idx < 4'(KEY_NUM)) key_file[key_idx] <= key_data;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // FSM next state.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_fire)   state_nx = ST_RUN;
            ST_RUN:  if (last_step) state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    // Datapath: block state, round counter and held output.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= '0;
            rnd       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        st  <= in_data;
                        rnd <= '0;
                    end
                end
                ST_RUN: begin
                    st  <= chain[UNROLL];
                    rnd <= rnd + RND_STEP;
                    if (last_step) begin
                        out_data  <= chain[UNROLL] ^ key_file[KEY_NUM-1];
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_kuz_encrypt_core.sv
// Directed bench for kuz_encrypt_core with UNROLL = 1, 3 and 9 side by side.
module tb_kuz_encrypt_core;

    localparam logic [127:0] PT = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] JUNK = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] KEYS [10] = '{
        128'h8899aabbccddeeff0011223344556677,
        128'hfedcba98765432100123456789abcdef,
        128'hdb31485315694343228d6aef8cc78c44,
        128'h3d4553d8e9cfec6815ebadc40a9ffd04,
        128'h57646468c44a5e28d3e59246f429f1ac,
        128'hbd079435165c6432b532e82834da581b,
        128'h51e640757e8745de705727265a0098b1,
        128'h5a7925017b9fdd3ed72a91a22286f984,
        128'hbb44e25378c73123a5f32f73cdb6e517,
        128'h72e9dd7416bcf45b755dbaa88e4a4043
    };
    localparam int LAT [3] = '{9, 3, 1};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         key_we    [3];
    logic [3:0]   key_idx   [3];
    logic [127:0] key_data  [3];
    logic         busy      [3];

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    // Clock.
    always #5 clk = ~clk;

    kuz_encrypt_core #(.UNROLL(1)) dut_u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .key_we(key_we[0]), .key_idx(key_idx[0]), .key_data(key_data[0]), .busy(busy[0])
    );
    kuz_encrypt_core #(.UNROLL(3)) dut_u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .key_we(key_we[1]), .key_idx(key_idx[1]), .key_data(key_data[1]), .busy(busy[1])
    );
    kuz_encrypt_core #(.UNROLL(9)) dut_u9 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .key_we(key_we[2]), .key_idx(key_idx[2]), .key_data(key_data[2]), .busy(busy[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a block to an idle core and let it be taken on the next edge.
    task automatic start_block(input int u, input logic [127:0] pt);
        in_data[u]  = pt;
        in_valid[u] = 1'b1;
        #1;
        chk_bit("in_ready_idle", in_ready[u], 1'b1);
        tick();
        in_valid[u] = 1'b0;
    endtask

    // Count edges from accept until out_valid, bounded.
    task automatic wait_out(input int u, output int n);
        n = 0;
        while (out_valid[u] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_block(input int u);
        out_ready[u] = 1'b1;
        tick();
        out_ready[u] = 1'b0;
        chk_bit("out_valid_drop", out_valid[u], 1'b0);
        chk_bit("busy_after_done", busy[u], 1'b0);
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_data[u] = '0; out_ready[u] = 1'b0;
            key_we[u] = 1'b0; key_idx[u] = '0; key_data[u] = '0;
        end

        // Reset state.
        repeat (3) tick();
        for (int u = 0; u < 3; u++) begin
            chk_bit("in_ready_in_rst", in_ready[u], 1'b0);
            chk_bit("out_valid_rst", out_valid[u], 1'b0);
            chk_blk("out_data_rst", out_data[u], '0);
            chk_bit("busy_rst", busy[u], 1'b0);
        end
        rst = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) chk_bit("in_ready_after_rst", in_ready[u], 1'b1);

        // Load K1..K10 into every core.
        for (int k = 0; k < 10; k++) begin
            for (int u = 0; u < 3; u++) begin
                key_we[u] = 1'b1; key_idx[u] = 4'(k); key_data[u] = KEYS[k];
            end
            tick();
        end
        for (int u = 0; u < 3; u++) key_we[u] = 1'b0;

        // Standard vector and latency for each unroll factor.
        for (int u = 0; u < 3; u++) begin
            start_block(u, PT);
            chk_bit("busy_run", busy[u], (LAT[u] > 1) ? 1'b1 : 1'b1);
            wait_out(u, lat);
            chk_int("latency", lat, LAT[u]);
            chk_blk("std_vector", out_data[u], CT);
            finish_block(u);
        end

        // Backpressure on UNROLL=1 with a competing input block.
        start_block(0, PT);
        wait_out(0, lat);
        chk_int("latency_bp", lat, 9);
        in_data[0]  = JUNK;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_bit("bp_out_valid", out_valid[0], 1'b1);
            chk_blk("bp_out_data", out_data[0], CT);
            chk_bit("bp_in_ready", in_ready[0], 1'b0);
            chk_bit("bp_busy", busy[0], 1'b1);
        end
        in_valid[0] = 1'b0;
        finish_block(0);

        // Key write during RUN is ignored.
        start_block(0, PT);
        tick();
        key_we[0] = 1'b1; key_idx[0] = 4'd0; key_data[0] = JUNK;
        tick();
        key_we[0] = 1'b0;
        wait_out(0, lat);
        chk_blk("key_we_in_run", out_data[0], CT);
        finish_block(0);

        // Key index above 9 in IDLE has no effect.
        key_we[0] = 1'b1; key_idx[0] = 4'd12; key_data[0] = JUNK;
        tick();
        key_we[0] = 1'b0;
        start_block(0, PT);
        wait_out(0, lat);
        chk_blk("key_idx_12", out_data[0], CT);
        finish_block(0);

        // Collision: corrupt K1, then rewrite it in the same cycle a block is offered.
        key_we[0] = 1'b1; key_idx[0] = 4'd0; key_data[0] = JUNK;
        tick();
        key_data[0] = KEYS[0];
        in_data[0]  = PT;
        in_valid[0] = 1'b1;
        #1;
        chk_bit("collision_in_ready", in_ready[0], 1'b0);
        tick();
        key_we[0] = 1'b0;
        chk_bit("collision_not_taken", busy[0], 1'b0);
        #1;
        chk_bit("collision_ready_next", in_ready[0], 1'b1);
        tick();
        in_valid[0] = 1'b0;
        chk_bit("collision_taken", busy[0], 1'b1);
        wait_out(0, lat);
        chk_int("collision_latency", lat, 9);
        chk_blk("collision_new_key", out_data[0], CT);
        finish_block(0);

        // Reset in the middle of RUN.
        start_block(0, PT);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_bit("mid_rst_busy", busy[0], 1'b0);
        chk_bit("mid_rst_out_valid", out_valid[0], 1'b0);
        chk_bit("mid_rst_in_ready", in_ready[0], 1'b1);
        start_block(0, PT);
        wait_out(0, lat);
        chk_int("post_rst_latency", lat, 9);
        chk_blk("post_rst_vector", out_data[0], CT);
        finish_block(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
